// File: rtl/beat_sequencer_pkg.sv
// Shared music-path definitions: sequencer state encoding and default song geometry.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } beat_state_t;

  localparam int BEAT_LEN_DEF = 256;
  localparam int BEAT_W_DEF   = 12;
  localparam int TEMPO_W_DEF  = 8;
  localparam int LOOP_CNT_W   = 8;

endpackage

// File: rtl/beat_sequencer_if.sv
// Control/status bundle between the game FSM (master) and the beat sequencer (slave).
// Carries loop_cnt only when BEAT_SEQ_LOOP_CNT_EN is defined.
interface beat_sequencer_if
  import music_pkg::*;
#(
  parameter int BEAT_W  = BEAT_W_DEF,
  parameter int TEMPO_W = TEMPO_W_DEF
);

  logic               en;
  logic               pause;
  logic               loop;
  logic               restart;
  logic [TEMPO_W-1:0] tempo;
  logic [BEAT_W-1:0]  ibeat;
  logic               beat_tick;
  logic               wrap;
  logic               ending;
  logic               playing;
`ifdef BEAT_SEQ_LOOP_CNT_EN
  logic [LOOP_CNT_W-1:0] loop_cnt;

  modport master (
    output en, pause, loop, restart, tempo,
    input  ibeat, beat_tick, wrap, ending, playing, loop_cnt
  );

  modport slave (
    input  en, pause, loop, restart, tempo,
    output ibeat, beat_tick, wrap, ending, playing, loop_cnt
  );
`else
  modport master (
    output en, pause, loop, restart, tempo,
    input  ibeat, beat_tick, wrap, ending, playing
  );

  modport slave (
    input  en, pause, loop, restart, tempo,
    output ibeat, beat_tick, wrap, ending, playing
  );
`endif

endinterface

// File: rtl/beat_sequencer_tempo_divider.sv
// Clock-per-beat divider: counts up to tempo and strobes adv when a beat is due.
module tempo_divider
  import music_pkg::*;
#(
  parameter int TEMPO_W = TEMPO_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               hold,
  input  logic [TEMPO_W-1:0] tempo,
  output logic               adv
);

  logic [TEMPO_W-1:0] div;

  // >= so a tempo lowered below the running count fires on the next cycle
  assign adv = (div >= tempo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (clear) begin
      div <= '0;
    end else if (hold) begin
      div <= div;
    end else if (adv) begin
      div <= '0;
    end else begin
      div <= div + TEMPO_W'(1);
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Beat-index generator with tempo, one-shot/loop, pause and restart control.
// Optional loop counter output enabled by defining BEAT_SEQ_LOOP_CNT_EN.
module beat_sequencer
  import music_pkg::*;
#(
  parameter int LEN     = BEAT_LEN_DEF,
  parameter int BEAT_W  = BEAT_W_DEF,
  parameter int TEMPO_W = TEMPO_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  beat_sequencer_if.slave bus
);

  localparam logic [1:0]        ST_IDLE  = IDLE;
  localparam logic [1:0]        ST_PLAY  = PLAY;
  localparam logic [1:0]        ST_PAUSE = PAUSE;
  localparam logic [1:0]        ST_DONE  = DONE;
  localparam logic [BEAT_W-1:0] LAST     = BEAT_W'(LEN - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [BEAT_W-1:0] ibeat;
  logic [BEAT_W-1:0] ibeat_nxt;
  logic              tick_nxt;
  logic              wrap_nxt;
  logic              beat_tick;
  logic              wrap;
  logic              ending;
  logic              playing;
  logic              adv;
  logic              div_clear;
  logic              div_hold;

  tempo_divider #(.TEMPO_W(TEMPO_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (div_clear),
    .hold  (div_hold),
    .tempo (bus.tempo),
    .adv   (adv)
  );

  // Priority: en low, then restart, then pause, then beat advance
  always_comb begin
    state_nxt = state;
    ibeat_nxt = ibeat;
    tick_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    div_clear = 1'b0;
    div_hold  = 1'b0;
    if (!bus.en) begin
      state_nxt = ST_IDLE;
      ibeat_nxt = '0;
      div_clear = 1'b1;
    end else if (bus.restart) begin
      state_nxt = ST_PLAY;
      ibeat_nxt = '0;
      div_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_PLAY;
          ibeat_nxt = '0;
          div_clear = 1'b1;
        end
        ST_PLAY: begin
          if (bus.pause) begin
            state_nxt = ST_PAUSE;
            div_hold  = 1'b1;
          end else if (adv) begin
            if (ibeat < LAST) begin
              ibeat_nxt = ibeat + BEAT_W'(1);
              tick_nxt  = 1'b1;
            end else if (bus.loop) begin
              ibeat_nxt = '0;
              tick_nxt  = 1'b1;
              wrap_nxt  = 1'b1;
            end else begin
              state_nxt = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          div_hold = 1'b1;
          if (!bus.pause) begin
            state_nxt = ST_PLAY;
          end
        end
        default: begin
          ibeat_nxt = LAST;
          div_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ibeat     <= '0;
      beat_tick <= 1'b0;
      wrap      <= 1'b0;
      ending    <= 1'b0;
      playing   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ibeat     <= ibeat_nxt;
      beat_tick <= tick_nxt;
      wrap      <= wrap_nxt;
      ending    <= (state_nxt == ST_DONE);
      playing   <= (state_nxt == ST_PLAY);
    end
  end

  assign bus.ibeat     = ibeat;
  assign bus.beat_tick = beat_tick;
  assign bus.wrap      = wrap;
  assign bus.ending    = ending;
  assign bus.playing   = playing;

`ifdef BEAT_SEQ_LOOP_CNT_EN
  logic [LOOP_CNT_W-1:0] loop_cnt;

  // Counts completed loops, saturating so a long session never rolls back to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_cnt <= '0;
    end else if (!bus.en || bus.restart) begin
      loop_cnt <= '0;
    end else if (wrap_nxt && (loop_cnt != {LOOP_CNT_W{1'b1}})) begin
      loop_cnt <= loop_cnt + LOOP_CNT_W'(1);
    end
  end

  assign bus.loop_cnt = loop_cnt;
`endif

endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Parametrised beat-index generator for the music path. It advances a beat index at a programmable tempo and supports one-shot or looping playback, pause/resume, restart and a registered end-of-song flag. The note/tone lookup ROM sits downstream and consumes `ibeat`. Play requests come from the game FSM upstream.

## Interface
- `LEN`, 256: song length in beats; legal range ≥ 2.
- `BEAT_W`, 12: `ibeat` width; must satisfy 2^BEAT_W ≥ LEN.
- `TEMPO_W`, 8: `tempo` width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `en`  in  1  play enable; low forces IDLE.
- `pause`  in  1  level; high freezes playback.
- `loop`  in  1  level; 1 = wrap at end, 0 = one-shot.
- `restart`  in  1  single-cycle pulse; jump to beat 0 and play.
- `tempo`  in  TEMPO_W  clocks per beat minus 1.
- `ibeat`  out  BEAT_W  current beat index.
- `beat_tick`  out  1  one-cycle pulse when `ibeat` changes.
- `wrap`  out  1  one-cycle pulse on loop wrap LEN-1 → 0.
- `ending`  out  1  level; high while in DONE.
- `playing`  out  1  level; high in PLAY.

## Operation
- States: IDLE, PLAY, PAUSE, DONE. Internal divider `div` is TEMPO_W bits.
- Input priority, evaluated every cycle: `en`=0 > `restart` > `pause` > beat advance.
- Any state with `en`=0: next state IDLE, `ibeat`=0, `div`=0, all pulses 0.
- IDLE with `en`=1: go to PLAY. `ibeat` stays 0, so beat 0 is played in full.
- PLAY:
  - If `div` ≥ `tempo`: `div` ← 0 and `beat_tick` = 1.
    - `ibeat` < LEN-1: increment `ibeat`.
    - `ibeat` = LEN-1 with `loop`=1: `ibeat` ← 0 and `wrap` = 1.
    - `ibeat` = LEN-1 with `loop`=0: go to DONE, hold `ibeat` = LEN-1, no tick.
  - Otherwise: `div` increments.
- Using ≥ means that lowering `tempo` mid-beat below the current `div` advances on the next cycle.
- PLAY with `pause`=1: go to PAUSE. `div` and `ibeat` are frozen.
- PAUSE with `pause`=0: return to PLAY and resume from the frozen `div`.
- `restart`=1 with `en`=1, in any state: `ibeat` ← 0, `div` ← 0, state ← PLAY. This overrides a simultaneous `pause` and a simultaneous advance.
- DONE: `ending`=1 and `ibeat`=LEN-1, held until `restart` or `en`=0.
- `loop` is sampled only at the LEN-1 boundary. Changing it elsewhere has no effect.
- `tempo` is sampled every cycle and is not latched.

## Timing
- Reset values: `ibeat`=0, `beat_tick`=0, `wrap`=0, `ending`=0, `playing`=0, state IDLE, `div`=0.
- All outputs are registered. There is no combinational input-to-output path.
- `beat_tick`, `wrap` and the new `ibeat` value appear on the same clock edge.
- Beat period is `tempo`+1 cycles. The first advance from 0 to 1 occurs `tempo`+1 cycles after the PLAY entry edge.
- `ending` rises on the same edge that enters DONE, which is `tempo`+1 cycles after `ibeat` reaches LEN-1.
- `playing` reflects the current state, one edge after the causing input.
- `rst_n` deassertion mid-song: restart in IDLE. No state is retained.

## Configuration
- Macro `BEAT_SEQ_LOOP_CNT_EN`.
- When defined:
  - Extra output `loop_cnt` [7:0] is added. It increments on every `wrap` and saturates at 255.
  - `loop_cnt` clears on reset, on `en`=0 and on `restart`.
- When undefined: neither the port nor the counter exists. All other behaviour is identical.

## Structure
- Shared package `music_pkg` holds:
  - state enum `beat_state_t` (IDLE, PLAY, PAUSE, DONE);
  - default constants `BEAT_LEN_DEF`=256 and `BEAT_W_DEF`=12.
- Sub-module `tempo_divider`:
  - owns `div`, with inputs clear, hold and `tempo`;
  - emits an internal `adv` strobe when `div` ≥ `tempo`.
- The top level owns the FSM and `ibeat`.

## Test plan
- LEN=4, `tempo`=2, `loop`=0, `en` rises → `ibeat` takes 0,1,2,3 with `beat_tick` every 3 cycles; `ending`=1 three cycles after `ibeat`=3; `ibeat` then holds 3.
- Same setup with `loop`=1 → `ibeat` sequence 3→0 with `wrap`=1 and `beat_tick`=1 on the same edge; no `ending`.
- Assert `pause` for 5 cycles when `div`=1 → `ibeat` and `div` frozen, `playing`=0; after release the next tick comes 2 cycles later.
- `restart` and `pause` together at `ibeat`=2 → next edge: `ibeat`=0, PLAY, `playing`=1.
- In DONE, drop `en` → next edge: `ibeat`=0, `ending`=0, IDLE. Separately, `rst_n` low mid-beat → all outputs 0 immediately (asynchronous).
- `tempo` 9→1 while `div`=5 → `beat_tick` on the next edge. With `BEAT_SEQ_LOOP_CNT_EN`: 3 wraps give `loop_cnt`=3.
